mdio_master: RTL



---
 rtl/mdio_pkg.sv | 36 +++
 rtl/mdio_clk_gen.sv | 58 +++++
 rtl/mdio_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants, FSM state type and frame-building helper for the
// Clause 22 MDIO master (mdio_master, mdio_clk_gen).
package mdio_pkg;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;  // turnaround pattern driven on writes

    localparam int FRAME_BITS = 64;
    localparam int TA_BIT     = 46;
    localparam int DATA_BIT   = 48;

    // Field lengths after the preamble (ST+OP+PHYAD+REGAD, TA, DATA).
    localparam int HDR_LEN  = 14;
    localparam int TA_LEN   = DATA_BIT - TA_BIT;
    localparam int DATA_LEN = FRAME_BITS - DATA_BIT;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_TA       = 3'd3,
        ST_DATA     = 3'd4
    } mdio_state_e;

    // Everything after the preamble, MSB = first bit on the wire. For reads the
    // TA/DATA part is never driven, so its content does not matter.
    function automatic logic [31:0] build_tx(input logic        is_wr,
                                             input logic [4:0]  phy,
                                             input logic [4:0]  regad,
                                             input logic [15:0] data);
        return {ST_CODE, (is_wr ? OP_WR : OP_RD), phy, regad, TA_WR, data};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC divider. While enabled, a counter runs 0..CLK_DIV-1 and
// mdc toggles at terminal count, giving an MDC period of 2*CLK_DIV clk cycles
// that starts with the low phase. When disabled, counter and mdc are held low.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   en          run the divider
//   mdc         management clock
//   rise_stb    high in the cycle whose closing clk edge raises mdc
//   fall_stb    high in the cycle whose closing clk edge lowers mdc
module mdio_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;
    logic             term;

    always_comb begin
        term  = en && (cnt_q == CNT_MAX);
        cnt_d = '0;
        mdc_d = 1'b0;
        if (en) begin
            if (term) begin
                cnt_d = '0;
                mdc_d = ~mdc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                mdc_d = mdc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc      = mdc_q;
    assign rise_stb = term && !mdc_q;
    assign fall_stb = term && mdc_q;

endmodule

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO management master. Serialises one
// write or read frame per accepted request onto MDC/MDIO and returns read data
// with a one-cycle strobe. The MDIO tristate buffer lives outside this block.
//
// Optional build macro: MDIO_TA_CHECK_EN adds rd_err, set with rd_valid when
// nothing pulled the second turnaround bit low during a read.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   phy_add, reg_add    request addresses (latched at accept)
//   wr_data             write data (latched at accept)
//   wren, rden          one-cycle request strobes; wren wins if both are high
//   busy                frame in progress
//   rd_data, rd_valid   last read result, one-cycle valid pulse
//   mdc, mdio_o, mdio_oe, mdio_i   PHY-side management interface
//   rd_err              (MDIO_TA_CHECK_EN only) no PHY answered the last read
//   dbg_state           current FSM state
module mdio_master import mdio_pkg::*; #(
    parameter int CLK_DIV       = 2,   // MDC half-period in clk cycles, >= 1
    parameter int PREAMBLE_BITS = 32   // 1..64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  phy_add,
    input  logic [4:0]  reg_add,
    input  logic [15:0] wr_data,
    input  logic        wren,
    input  logic        rden,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
`ifdef MDIO_TA_CHECK_EN
    output logic        rd_err,
`endif
    output mdio_state_e dbg_state
);

    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_BITS - 1);
    localparam logic [5:0] HDR_LAST  = 6'(HDR_LEN - 1);
    localparam logic [5:0] TA_LAST   = 6'(TA_LEN - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_LEN - 1);

    mdio_state_e  state_q, state_d;
    logic [5:0]   bit_cnt_q, bit_cnt_d;
    logic         is_wr_q, is_wr_d;
    logic [31:0]  tx_q, tx_d;
    logic [15:0]  rx_q, rx_d;
    logic [15:0]  rd_data_q, rd_data_d;
    logic         rd_valid_q, rd_valid_d;
`ifdef MDIO_TA_CHECK_EN
    logic         ta_bad_q, ta_bad_d;
    logic         rd_err_q, rd_err_d;
`endif

    logic rise_stb, fall_stb;
    logic req_accept;

    // Request handshake: wren/rden act as a one-cycle valid, !busy is the
    // ready. A request is taken on the clk edge where (wren|rden) && !busy;
    // anything presented while busy is dropped, never queued.
    assign req_accept = (wren || rden) && !busy;

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy),
        .mdc      (mdc),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Every state change and every new MDIO bit happens on fall_stb, i.e. at a
    // bit boundary; mdio_i is only looked at on rise_stb.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        is_wr_d    = is_wr_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef MDIO_TA_CHECK_EN
        ta_bad_d   = ta_bad_q;
        rd_err_d   = rd_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    state_d   = ST_PREAMBLE;
                    bit_cnt_d = '0;
                    is_wr_d   = wren;
                    tx_d      = build_tx(wren, phy_add, reg_add, wr_data);
`ifdef MDIO_TA_CHECK_EN
                    ta_bad_d  = 1'b0;
                    rd_err_d  = 1'b0;
`endif
                end
            end
            ST_PREAMBLE: begin
                if (fall_stb) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = ST_HEADER;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            ST_HEADER: begin
                if (fall_stb) begin
                    tx_d = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q == HDR_LAST) begin
                        state_d   = ST_TA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            ST_TA: begin
`ifdef MDIO_TA_CHECK_EN
                // A responding PHY pulls the second TA bit low.
                if (rise_stb && !is_wr_q && bit_cnt_q == TA_LAST) begin
                    ta_bad_d = mdio_i;
                end
`endif
                if (fall_stb) begin
                    tx_d = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q == TA_LAST) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            ST_DATA: begin
                if (rise_stb && !is_wr_q) begin
                    rx_d = {rx_q[14:0], mdio_i};
                end
                if (fall_stb) begin
                    tx_d = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q == DATA_LAST) begin
                        // The last data bit was sampled at the preceding rise.
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        if (!is_wr_q) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = rx_q;
`ifdef MDIO_TA_CHECK_EN
                            rd_err_d   = ta_bad_q;
`endif
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            is_wr_q    <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef MDIO_TA_CHECK_EN
            ta_bad_q   <= 1'b0;
            rd_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            is_wr_q    <= is_wr_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef MDIO_TA_CHECK_EN
            ta_bad_q   <= ta_bad_d;
            rd_err_q   <= rd_err_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    // Reads release the line from the first TA bit to the end of the frame.
    assign mdio_oe  = busy && (is_wr_q || state_q == ST_PREAMBLE || state_q == ST_HEADER);
    // Idle and preamble both drive 1; later fields come from the shifter MSB.
    assign mdio_o   = (state_q == ST_HEADER || state_q == ST_TA || state_q == ST_DATA)
                      ? tx_q[31] : 1'b1;
    assign dbg_state = state_q;
`ifdef MDIO_TA_CHECK_EN
    assign rd_err   = rd_err_q;
`endif

endmodule
